// File: rtl/div_tick_ctrl_pkg.sv
// Shared definitions for the programmable divide-by-N tick controller.
// State encoding and the smallest divisor the controller will run with.
package div_tick_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DIV_MIN = 2;

endpackage

// File: rtl/div_tick_counter.sv
// Period counter: counts 0..limit-1 while enabled and flags the terminal count.
// clear has priority over enable and forces the count back to zero.
module div_tick_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;

  // limit is always >= 2, so limit-1 cannot wrap around
  assign tc = (cnt_reg == (limit - ONE));

  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (enable) begin
      cnt_next = tc ? '0 : cnt_reg + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/div_tick_ctrl.sv
// Programmable divide-by-N tick controller with start/stop and handshaked divisor updates.
// Define DIV_TICK_CTRL_BURST_EN to add finite bursts (burst_len / done ports).
module div_tick_ctrl
  import div_tick_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             busy,
  output logic             tick,
`ifdef DIV_TICK_CTRL_BURST_EN
  input  logic [WIDTH-1:0] burst_len,
  output logic             done,
`endif
  output logic [WIDTH-1:0] cur_div
);

  localparam logic [WIDTH-1:0] DIV_MIN_W  = WIDTH'(DIV_MIN);
  localparam logic [WIDTH-1:0] DIV_RESET  = WIDTH'(DEFAULT_DIV);

  state_t           state_reg;
  logic [WIDTH-1:0] cur_div_reg;
  logic [WIDTH-1:0] pend_div_reg;
  logic             pend_valid_reg;
  logic             cfg_err_reg;

  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             run;
  logic             accept;
  logic             legal;
  logic             burst_fin;
  logic             leave_run;

  assign run       = (state_reg == ST_RUN);
  assign cfg_ready = !pend_valid_reg;
  assign accept    = cfg_valid && cfg_ready;
  assign legal     = (cfg_div >= DIV_MIN_W);
  assign leave_run = run && (stop || burst_fin);

  div_tick_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (!run || leave_run),
    .enable (run),
    .limit  (cur_div_reg),
    .cnt    (cnt),
    .tc     (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cur_div_reg    <= DIV_RESET;
      pend_div_reg   <= DIV_RESET;
      pend_valid_reg <= 1'b0;
      cfg_err_reg    <= 1'b0;
    end else begin
      cfg_err_reg <= accept && !legal;

      case (state_reg)
        ST_IDLE: if (start && !stop) state_reg <= ST_RUN;
        ST_RUN:  if (leave_run)      state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase

      // A held value lands on a period boundary or when leaving RUN
      if (pend_valid_reg && run && (tc || leave_run)) begin
        cur_div_reg    <= pend_div_reg;
        pend_valid_reg <= 1'b0;
      end

      // accept implies the slot is empty, so this never races the commit above
      if (accept && legal) begin
        if (!run || leave_run) begin
          cur_div_reg <= cfg_div;
        end else begin
          pend_div_reg   <= cfg_div;
          pend_valid_reg <= 1'b1;
        end
      end
    end
  end

`ifdef DIV_TICK_CTRL_BURST_EN
  logic [WIDTH-1:0] burst_len_reg;
  logic [WIDTH-1:0] tick_cnt_reg;
  logic             done_reg;

  // The Nth tick has already been counted by the time its period wraps
  assign burst_fin = run && tc && (burst_len_reg != '0) && (tick_cnt_reg == burst_len_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_len_reg <= '0;
      tick_cnt_reg  <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= burst_fin && !stop;
      if (!run && start && !stop) begin
        burst_len_reg <= burst_len;
        tick_cnt_reg  <= '0;
      end else if (tick && (burst_len_reg != '0)) begin
        tick_cnt_reg <= tick_cnt_reg + WIDTH'(1);
      end
    end
  end

  assign done = done_reg;
`else
  assign burst_fin = 1'b0;
`endif

  assign tick    = run && (cnt == '0);
  assign busy    = run;
  assign cfg_err = cfg_err_reg;
  assign cur_div = cur_div_reg;

endmodule
